// File: rtl/dp_sched_pkg.sv
// Shared types and default sizing for the dot-product scheduler.
package dp_sched_pkg;

  localparam int WIDTH_DEF     = 4;
  localparam int NUM_PRODS_DEF = 16;
  localparam int LEN_W_DEF     = 8;
  localparam int ACC_W_DEF     = 20;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LAUNCH,
    RUN,
    RESULT
  } state_e;

  typedef logic [NUM_PRODS_DEF-1:0] lane_mask_t;

endpackage

// File: rtl/dp_lane_tracker.sv
// Lane bookkeeping for the scheduler. It decides which lanes may be launched
// (both operands non-zero), remembers which launched lanes are still running,
// and reports when the whole chunk has drained.
module dp_lane_tracker
  import dp_sched_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int NUM_PRODS = NUM_PRODS_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_PRODS*WIDTH-1:0] pb_w,
  input  logic [NUM_PRODS*WIDTH-1:0] pb_x,
  input  logic                       launch,
  input  logic                       run,
  input  logic [NUM_PRODS-1:0]       pb_done,
  output logic [NUM_PRODS-1:0]       launch_mask,
  output logic [NUM_PRODS-1:0]       busy,
  output logic                       all_idle
);

  // A zero operand would hang a lane, so such lanes are never launched.
  always_comb begin
    launch_mask = '0;
    for (int i = 0; i < NUM_PRODS; i++) begin
      launch_mask[i] = (|pb_w[i*WIDTH +: WIDTH]) && (|pb_x[i*WIDTH +: WIDTH]);
    end
  end

  // Busy lanes are set at launch and retire on their done flag while running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else if (launch) begin
      busy <= launch_mask;
    end else if (run) begin
      busy <= busy & ~pb_done;
    end
  end

  // Looks through this cycle's done flags so the last retiring lane ends the chunk
  // on the same edge.
  always_comb begin
    all_idle = ((busy & ~pb_done) == '0);
  end

endmodule

// File: rtl/dot_product_scheduler.sv
// Dot-product scheduler: accepts a job of N chunks, launches product lanes per
// chunk, integrates the adder-tree sum until the lanes drain, returns the total.
//
// state  | meaning
// IDLE   | waiting for a job, job_ready high
// FETCH  | waiting for chunk operands, chk_ready high
// LAUNCH | one-cycle launch pulse to lanes with non-zero operands
// RUN    | accumulate tree_sum until every launched lane is done
// RESULT | res_valid high with stable total until accepted
module dot_product_scheduler
  import dp_sched_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int NUM_PRODS = NUM_PRODS_DEF,
  parameter int TREE_W    = $clog2(NUM_PRODS + 1),
  parameter int LEN_W     = LEN_W_DEF,
  parameter int ACC_W     = ACC_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [LEN_W-1:0]           job_len,
  input  logic                       chk_valid,
  output logic                       chk_ready,
  input  logic [NUM_PRODS*WIDTH-1:0] chk_w,
  input  logic [NUM_PRODS*WIDTH-1:0] chk_x,
  output logic [NUM_PRODS-1:0]       pb_in_rdy,
  output logic [NUM_PRODS*WIDTH-1:0] pb_w,
  output logic [NUM_PRODS*WIDTH-1:0] pb_x,
  input  logic [NUM_PRODS-1:0]       pb_done,
  input  logic [TREE_W-1:0]          tree_sum,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ACC_W-1:0]           res_data,
  output logic                       res_ovf
);

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     len_q;
  logic [ACC_W-1:0]     acc_q;
  logic                 ovf_q;
  logic [ACC_W:0]       acc_sum;
  logic [NUM_PRODS-1:0] launch_mask;
  logic [NUM_PRODS-1:0] busy;
  logic                 all_idle;

  dp_lane_tracker #(
    .WIDTH     (WIDTH),
    .NUM_PRODS (NUM_PRODS)
  ) u_tracker (
    .clk         (clk),
    .reset_n     (reset_n),
    .pb_w        (pb_w),
    .pb_x        (pb_x),
    .launch      (state_q == LAUNCH),
    .run         (state_q == RUN),
    .pb_done     (pb_done),
    .launch_mask (launch_mask),
    .busy        (busy),
    .all_idle    (all_idle)
  );

  // Extra top bit of the sum is the wrap carry that feeds the sticky overflow.
  assign acc_sum = {1'b0, acc_q} + {{(ACC_W + 1 - TREE_W){1'b0}}, tree_sum};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    job_ready = 1'b0;
    chk_ready = 1'b0;
    res_valid = 1'b0;
    pb_in_rdy = '0;
    case (state_q)
      IDLE: begin
        job_ready = 1'b1;
        if (job_valid) state_d = (job_len != '0) ? FETCH : RESULT;
      end
      FETCH: begin
        chk_ready = 1'b1;
        if (chk_valid) state_d = LAUNCH;
      end
      LAUNCH: begin
        pb_in_rdy = launch_mask;
        state_d   = RUN;
      end
      RUN: begin
        if (all_idle) state_d = (len_q != LEN_W'(1)) ? FETCH : RESULT;
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: chunk counter, operand capture and the accumulator.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      len_q <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
      pb_w  <= '0;
      pb_x  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (job_valid) begin
            len_q <= job_len;
            acc_q <= '0;
            ovf_q <= 1'b0;
          end
        end
        FETCH: begin
          if (chk_valid) begin
            pb_w <= chk_w;
            pb_x <= chk_x;
          end
        end
        RUN: begin
          acc_q <= acc_sum[ACC_W-1:0];
          ovf_q <= ovf_q | acc_sum[ACC_W];
          if (all_idle) len_q <= len_q - LEN_W'(1);
        end
        RESULT: begin
          if (res_ready) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign res_data = acc_q;
  assign res_ovf  = ovf_q;

endmodule

// File: tb/tb_dot_product_scheduler.sv
// Directed bench for dot_product_scheduler with a behavioural product-lane bank.
// A second instance with an 8-bit accumulator shares the same stimulus and lanes.
module tb_dot_product_scheduler;
  import dp_sched_pkg::*;

  localparam int NP = 16;
  localparam int WD = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          job_valid = 1'b0;
  logic [7:0]    job_len = '0;
  logic          chk_valid = 1'b0;
  logic [63:0]   chk_w = '0;
  logic [63:0]   chk_x = '0;
  logic          res_ready = 1'b0;
  logic [NP-1:0] pb_done;
  logic [4:0]    tree_sum;

  logic          job_ready, chk_ready, res_valid, res_ovf;
  logic [NP-1:0] pb_in_rdy;
  logic [63:0]   pb_w, pb_x;
  logic [19:0]   res_data;

  logic          job_ready8, chk_ready8, res_valid8, res_ovf8;
  logic [NP-1:0] pb_in_rdy8;
  logic [63:0]   pb_w8, pb_x8;
  logic [7:0]    res_data8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dot_product_scheduler dut (
    .clk(clk), .reset_n(reset_n), .job_valid(job_valid), .job_ready(job_ready),
    .job_len(job_len), .chk_valid(chk_valid), .chk_ready(chk_ready),
    .chk_w(chk_w), .chk_x(chk_x), .pb_in_rdy(pb_in_rdy), .pb_w(pb_w), .pb_x(pb_x),
    .pb_done(pb_done), .tree_sum(tree_sum), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data), .res_ovf(res_ovf)
  );

  dot_product_scheduler #(.ACC_W(8)) dut8 (
    .clk(clk), .reset_n(reset_n), .job_valid(job_valid), .job_ready(job_ready8),
    .job_len(job_len), .chk_valid(chk_valid), .chk_ready(chk_ready8),
    .chk_w(chk_w), .chk_x(chk_x), .pb_in_rdy(pb_in_rdy8), .pb_w(pb_w8), .pb_x(pb_x8),
    .pb_done(pb_done), .tree_sum(tree_sum), .res_valid(res_valid8),
    .res_ready(res_ready), .res_data(res_data8), .res_ovf(res_ovf8)
  );

  // Lane model: after launch, emit w*x ones, then a one-cycle done.
  int ones_q [NP];
  bit act_q  [NP];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NP; i++) begin
        ones_q[i] <= 0;
        act_q[i]  <= 1'b0;
      end
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (pb_in_rdy[i]) begin
          ones_q[i] <= int'(pb_w[i*WD +: WD]) * int'(pb_x[i*WD +: WD]);
          act_q[i]  <= 1'b1;
        end else if (act_q[i]) begin
          if (ones_q[i] > 0) ones_q[i] <= ones_q[i] - 1;
          else               act_q[i]  <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    pb_done  = '0;
    tree_sum = '0;
    for (int i = 0; i < NP; i++) begin
      if (act_q[i] && ones_q[i] > 0)  tree_sum = tree_sum + 5'd1;
      if (act_q[i] && ones_q[i] == 0) pb_done[i] = 1'b1;
    end
  end

  // Launch monitor: number of launch cycles and the last launch mask seen.
  int            n_launch = 0;
  logic [NP-1:0] last_mask = '0;
  always @(posedge clk) begin
    if (|pb_in_rdy) begin
      n_launch  <= n_launch + 1;
      last_mask <= pb_in_rdy;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic send_job(input string tag, input logic [7:0] len);
    int cyc = 0;
    while (!job_ready && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    if (!job_ready) check_eq({tag, "_job_timeout"}, 0, 1);
    job_valid = 1'b1;
    job_len   = len;
    @(posedge clk); #1;
    job_valid = 1'b0;
  endtask

  task automatic send_chunk(input string tag, input logic [63:0] w, input logic [63:0] x);
    int cyc = 0;
    while (!chk_ready && cyc < 600) begin
      @(posedge clk); #1; cyc++;
    end
    if (!chk_ready) check_eq({tag, "_chk_timeout"}, 0, 1);
    chk_valid = 1'b1;
    chk_w     = w;
    chk_x     = x;
    @(posedge clk); #1;
    chk_valid = 1'b0;
  endtask

  task automatic take_result(input string tag, output logic [19:0] d, output logic o,
                             output logic [7:0] d8, output logic o8, output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 600) begin
      @(posedge clk); #1; cyc++;
    end
    if (!res_valid) check_eq({tag, "_res_timeout"}, 0, 1);
    d  = res_data;
    o  = res_ovf;
    d8 = res_data8;
    o8 = res_ovf8;
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    check_eq({tag, "_res_single"}, 32'(res_valid), 0);
    check_eq({tag, "_back_idle"}, 32'(job_ready), 1);
  endtask

  logic [19:0] d;
  logic        o;
  logic [7:0]  d8;
  logic        o8;
  int          cyc;
  int          l0;

  initial begin
    // Reset state
    #2;
    check_eq("rst_job_ready", 32'(job_ready), 1);
    check_eq("rst_chk_ready", 32'(chk_ready), 0);
    check_eq("rst_res_valid", 32'(res_valid), 0);
    check_eq("rst_pb_in_rdy", 32'(pb_in_rdy), 0);
    check_eq("rst_res_data",  32'(res_data), 0);
    check_eq("rst_res_ovf",   32'(res_ovf), 0);
    #20 reset_n = 1'b1;
    @(posedge clk); #1;

    // 1) one chunk, every lane 3*2
    send_job("t1", 8'd1);
    check_eq("t1_fetch", 32'(chk_ready), 1);
    send_chunk("t1", 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222);
    check_eq("t1_launch_mask", 32'(pb_in_rdy), 32'hFFFF);
    take_result("t1", d, o, d8, o8, cyc);
    check_eq("t1_data", 32'(d), 96);
    check_eq("t1_ovf",  32'(o), 0);

    // 2) two chunks: lane0 15*15, then all lanes 1*1
    send_job("t2", 8'd2);
    send_chunk("t2a", 64'h0000_0000_0000_000F, 64'h0000_0000_0000_000F);
    check_eq("t2a_mask", 32'(pb_in_rdy), 32'h0001);
    send_chunk("t2b", 64'h1111_1111_1111_1111, 64'h1111_1111_1111_1111);
    check_eq("t2b_mask", 32'(pb_in_rdy), 32'hFFFF);
    take_result("t2", d, o, d8, o8, cyc);
    check_eq("t2_data", 32'(d), 241);
    check_eq("t2_ovf",  32'(o), 0);

    // 3) every lane has a zero operand: no launch, quick zero result
    l0 = n_launch;
    send_job("t3", 8'd1);
    send_chunk("t3", 64'h0000_0000_FFFF_FFFF, 64'h9999_9999_0000_0000);
    take_result("t3", d, o, d8, o8, cyc);
    check_eq("t3_no_launch", 32'(n_launch - l0), 0);
    check_eq("t3_data", 32'(d), 0);
    check_eq("t3_fast", 32'(cyc <= 4), 1);

    // 4) empty job: result next cycle, held while res_ready low
    send_job("t4", 8'd0);
    check_eq("t4_res_next", 32'(res_valid), 1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_eq("t4_hold_valid", 32'(res_valid), 1);
      check_eq("t4_hold_data",  32'(res_data), 0);
    end
    take_result("t4", d, o, d8, o8, cyc);
    check_eq("t4_data", 32'(d), 0);

    // 5) all lanes 15*15: 3600 fits 20 bits, wraps an 8-bit accumulator
    send_job("t5", 8'd1);
    send_chunk("t5", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    take_result("t5", d, o, d8, o8, cyc);
    check_eq("t5_data20", 32'(d), 3600);
    check_eq("t5_ovf20",  32'(o), 0);
    check_eq("t5_data8",  32'(d8), 16);
    check_eq("t5_ovf8",   32'(o8), 1);
    check_eq("t5_ovf_clr", 32'(res_ovf8), 0);

    // 6) asynchronous reset in the middle of RUN, then a clean job
    send_job("t6", 8'd1);
    send_chunk("t6", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (20) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check_eq("t6_job_ready", 32'(job_ready), 1);
    check_eq("t6_chk_ready", 32'(chk_ready), 0);
    check_eq("t6_res_valid", 32'(res_valid), 0);
    check_eq("t6_res_data",  32'(res_data), 0);
    check_eq("t6_pb_w",      32'(pb_w[31:0]), 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    send_job("t6b", 8'd1);
    send_chunk("t6b", 64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222);
    take_result("t6b", d, o, d8, o8, cyc);
    check_eq("t6b_data", 32'(d), 96);
    check_eq("t6b_ovf",  32'(o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
